// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: in-order memory reads, DEPTH-entry response FIFO, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_queue_unit #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_INC   = 1,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_rvalid,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard;
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];

    logic rsp_ok;
    logic rsp_keep;
    logic fifo_nonempty;
    logic byp;
    logic byp_take;
    logic push;
    logic pop;

    // Issue credit, response classification and decode-side view of the queue.
    always_comb begin
        rsp_ok        = mem_rvalid && (outstanding != '0);
        rsp_keep      = rsp_ok && (discard == '0) && !redirect;
        fifo_nonempty = (count != '0);
        mem_en        = !reset && !redirect &&
                        ((SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH));
        mem_addr      = fetch_pc;
`ifdef FETCH_BYPASS_EN
        byp           = !fifo_nonempty && rsp_keep;
`else
        byp           = 1'b0;
`endif
        byp_take      = byp && instr_ready;
        push          = rsp_keep && !byp_take;
        pop           = fifo_nonempty && instr_ready;
        instr_valid   = fifo_nonempty || byp;
        instr         = '0;
        instr_pc      = '0;
        if (fifo_nonempty) begin
            instr    = fifo_instr[rd_ptr];
            instr_pc = fifo_pc[rd_ptr];
        end else if (byp) begin
            instr    = mem_rdata;
            instr_pc = resp_pc;
        end
    end

    // Control state: PCs, pointers, occupancy, in-flight and stale-response counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= ADDR_W'(RESET_PC);
            resp_pc     <= ADDR_W'(RESET_PC);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(mem_en) - CNT_W'(rsp_ok);
            if (redirect) begin
                // Everything still in flight after this cycle's response belongs to the old path.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding - CNT_W'(rsp_ok);
            end else begin
                if (mem_en) begin
                    fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
                end
                if (rsp_keep) begin
                    resp_pc <= resp_pc + ADDR_W'(PC_INC);
                end
                if (rsp_ok && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Entry storage; contents are only observed through count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            fifo_instr[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule
